// File: rtl/cnn_bias_relu_64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_bias_relu_64_pkg
// Brief    : Shared constants, FP32 field layout and helpers for the
//            bias-add / ReLU stage and its FP32 adder.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_bias_relu_64_pkg;

    localparam int c_data_width = 32;
    localparam int c_sign_bit   = c_data_width - 1;
    // Fixed latency of cnn_bias_relu_64_fp_add_sub, input to result
    localparam int c_l_add      = 2;

    localparam logic [c_data_width-1:0] c_fp32_zero = '0;
    localparam logic [c_data_width-1:0] c_fp32_qnan = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    // Leading-zero count of a 27-bit mantissa-plus-guard word (27 when zero)
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_bias_relu_64_fp_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : cnn_bias_relu_64_fp_add_sub
// Brief    : Two-stage pipelined IEEE-754 single-precision adder/subtractor,
//            round-to-nearest-even, denormal aware, canonical quiet NaN out.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_bias_relu_64_fp_add_sub
    import cnn_bias_relu_64_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_sub,
    input  logic [c_data_width-1:0] i_a,
    input  logic [c_data_width-1:0] i_b,
    output logic [c_data_width-1:0] o_result,
    output logic                    o_valid
);

    // ---------------- stage 1: unpack, order by magnitude, align ----------
    fp32_t                   w_a, w_b;
    logic                    w_b_sign;
    logic [7:0]              w_ea, w_eb, w_el, w_es, w_diff;
    logic [23:0]             w_ma, w_mb, w_ml, w_ms;
    logic                    w_a_ge, w_sl, w_ss;
    logic [26:0]             w_ms_ext, w_ms_shr, w_ms_al;
    logic                    w_sticky;
    logic                    w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special;
    logic [c_data_width-1:0] w_special_val;

    assign w_a      = fp32_t'(i_a);
    assign w_b      = fp32_t'(i_b);
    assign w_b_sign = w_b.sign ^ i_sub;

    // Denormals use exponent 1 with no hidden bit
    assign w_ea = (w_a.exp == 8'h00) ? 8'h01 : w_a.exp;
    assign w_eb = (w_b.exp == 8'h00) ? 8'h01 : w_b.exp;
    assign w_ma = {(w_a.exp != 8'h00), w_a.man};
    assign w_mb = {(w_b.exp != 8'h00), w_b.man};

    assign w_a_nan = (w_a.exp == 8'hFF) && (w_a.man != 23'h0);
    assign w_b_nan = (w_b.exp == 8'hFF) && (w_b.man != 23'h0);
    assign w_a_inf = (w_a.exp == 8'hFF) && (w_a.man == 23'h0);
    assign w_b_inf = (w_b.exp == 8'hFF) && (w_b.man == 23'h0);

    // NaN / infinity results bypass the arithmetic path
    always_comb begin
        w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b_sign)))
            w_special_val = c_fp32_qnan;
        else if (w_a_inf)
            w_special_val = {w_a.sign, 8'hFF, 23'h0};
        else
            w_special_val = {w_b_sign, 8'hFF, 23'h0};
    end

    // Put the larger magnitude on the "l" side so the difference is never negative
    always_comb begin
        w_a_ge = {w_ea, w_ma} >= {w_eb, w_mb};
        w_el   = w_a_ge ? w_ea : w_eb;
        w_es   = w_a_ge ? w_eb : w_ea;
        w_ml   = w_a_ge ? w_ma : w_mb;
        w_ms   = w_a_ge ? w_mb : w_ma;
        w_sl   = w_a_ge ? w_a.sign : w_b_sign;
        w_ss   = w_a_ge ? w_b_sign : w_a.sign;
        w_diff = w_el - w_es;
    end

    // Right-align the smaller operand, keeping guard/round and a sticky LSB
    always_comb begin
        w_ms_ext = {w_ms, 3'b000};
        w_ms_shr = w_ms_ext >> w_diff;
        w_sticky = |(w_ms_ext & ((27'd1 << w_diff) - 27'd1));
        if (w_diff >= 8'd27)
            w_ms_al = {26'd0, |w_ms};
        else
            w_ms_al = {w_ms_shr[26:1], w_ms_shr[0] | w_sticky};
    end

    logic                    r1_valid, r1_special, r1_sign, r1_eff_sub;
    logic [c_data_width-1:0] r1_special_val;
    logic [7:0]              r1_exp;
    logic [26:0]             r1_ml, r1_ms;

    // Stage 1 pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid       <= 1'b0;
            r1_special     <= 1'b0;
            r1_special_val <= '0;
            r1_sign        <= 1'b0;
            r1_eff_sub     <= 1'b0;
            r1_exp         <= '0;
            r1_ml          <= '0;
            r1_ms          <= '0;
        end else begin
            r1_valid       <= i_valid;
            r1_special     <= w_special;
            r1_special_val <= w_special_val;
            r1_sign        <= w_sl;
            r1_eff_sub     <= w_sl ^ w_ss;
            r1_exp         <= w_el;
            r1_ml          <= {w_ml, 3'b000};
            r1_ms          <= w_ms_al;
        end
    end

    // ---------------- stage 2: add, normalise, round, pack ----------------
    logic [27:0]             w_sum;
    logic [4:0]              w_lz;
    logic [9:0]              w_e, w_shift;
    logic [26:0]             w_norm;
    logic                    w_round_up;
    logic [24:0]             w_man_r;
    logic [c_data_width-1:0] w_result;

    assign w_sum = r1_eff_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                              : ({1'b0, r1_ml} + {1'b0, r1_ms});
    assign w_lz  = clz27(w_sum[26:0]);

    // Normalise (left shift limited so the result lands on denormal range) and round-to-nearest-even
    always_comb begin
        w_e     = {2'b00, r1_exp};
        w_shift = '0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], |w_sum[1:0]};
            w_e    = w_e + 10'd1;
        end else begin
            if ({5'b0, w_lz} < w_e)
                w_shift = {5'b0, w_lz};
            else
                w_shift = w_e - 10'd1;
            w_norm = w_sum[26:0] << w_shift;
            w_e    = w_e - w_shift;
        end
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_man_r    = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
        if (w_man_r[24]) begin
            w_man_r = w_man_r >> 1;
            w_e     = w_e + 10'd1;
        end
        if (r1_special)
            w_result = r1_special_val;
        else if (w_sum == 28'd0)
            w_result = {~r1_eff_sub & r1_sign, 31'd0};
        else if (w_e >= 10'd255)
            w_result = {r1_sign, 8'hFF, 23'h0};
        else
            w_result = {r1_sign, (w_man_r[23] ? w_e[7:0] : 8'h00), w_man_r[22:0]};
    end

    logic                    r2_valid;
    logic [c_data_width-1:0] r2_result;

    // Stage 2 pipeline register drives the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid  <= 1'b0;
            r2_result <= '0;
        end else begin
            r2_valid  <= r1_valid;
            r2_result <= w_result;
        end
    end

    assign o_valid  = r2_valid;
    assign o_result = r2_result;

endmodule
`default_nettype wire

// File: rtl/cnn_bias_relu_64.sv
`default_nettype none
// ============================================================================
// Module   : cnn_bias_relu_64
// Brief    : Per-output-channel FP32 bias add followed by optional ReLU on a
//            channel-major conv output stream; flags the end of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_bias_relu_64
    import cnn_bias_relu_64_pkg::*;
#(
    parameter int DATA_WIDTH      = c_data_width,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int RELU_EN         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stride2,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  bias_loaded,
    output logic                  frame_done
);

    localparam int c_pix_full = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int c_pix_half = (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);
    localparam int c_pix_w    = (c_pix_full > 1) ? $clog2(c_pix_full) : 1;
    localparam int c_ch_w     = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

    localparam logic [c_pix_w-1:0] c_pix_last_full = c_pix_w'(c_pix_full - 1);
    localparam logic [c_pix_w-1:0] c_pix_last_half = c_pix_w'(c_pix_half - 1);
    localparam logic [c_ch_w-1:0]  c_ch_last       = c_ch_w'(CHANNEL_NUM_OUT - 1);

    // ---------------- position counters and stride latch -----------------
    logic [c_pix_w-1:0] r_pix_cnt;
    logic [c_ch_w-1:0]  r_ch_cnt;
    logic               r_stride;
    logic               w_frame_start, w_stride_eff, w_pix_last, w_ch_last, w_last;

    // The first sample of a frame must already see the stride it latches
    assign w_frame_start = (r_pix_cnt == '0) && (r_ch_cnt == '0);
    assign w_stride_eff  = w_frame_start ? stride2 : r_stride;
    assign w_pix_last    = w_stride_eff ? (r_pix_cnt == c_pix_last_half)
                                        : (r_pix_cnt == c_pix_last_full);
    assign w_ch_last     = (r_ch_cnt == c_ch_last);
    assign w_last        = valid_in && w_pix_last && w_ch_last;

    // Pixel/channel counters advance per accepted sample; gaps freeze them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
            r_ch_cnt  <= '0;
            r_stride  <= 1'b0;
        end else if (valid_in) begin
            if (w_frame_start)
                r_stride <= stride2;
            if (w_pix_last) begin
                r_pix_cnt <= '0;
                r_ch_cnt  <= w_ch_last ? '0 : r_ch_cnt + c_ch_w'(1);
            end else begin
                r_pix_cnt <= r_pix_cnt + c_pix_w'(1);
            end
        end
    end

    // ---------------- bias register file ---------------------------------
    logic [DATA_WIDTH-1:0] r_bias [CHANNEL_NUM_OUT];
    logic [c_ch_w-1:0]     r_bias_wr_addr;
    logic                  r_bias_loaded;
    logic [DATA_WIDTH-1:0] w_bias;

    // Combinational read of the registered array returns the pre-write value
    assign w_bias = r_bias[r_ch_cnt];

    // Sequential bias loading with wrap; loaded flag sticks until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNEL_NUM_OUT; i++)
                r_bias[i] <= '0;
            r_bias_wr_addr <= '0;
            r_bias_loaded  <= 1'b0;
        end else if (valid_bias_in) begin
            r_bias[r_bias_wr_addr] <= bias_in;
            if (r_bias_wr_addr == c_ch_last) begin
                r_bias_wr_addr <= '0;
                r_bias_loaded  <= 1'b1;
            end else begin
                r_bias_wr_addr <= r_bias_wr_addr + c_ch_w'(1);
            end
        end
    end

    // ---------------- stage A: FP32 add -----------------------------------
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_add_valid;

    cnn_bias_relu_64_fp_add_sub u_fp_add_sub (
        .clk      (clk),
        .rst      (reset),
        .i_valid  (valid_in),
        .i_sub    (1'b0),
        .i_a      (pxl_in),
        .i_b      (w_bias),
        .o_result (w_sum),
        .o_valid  (w_add_valid)
    );

    // Last-sample flag rides alongside the adder pipeline
    logic [c_l_add-1:0] r_last_pipe;

    generate
        if (c_l_add > 1) begin : g_last_pipe_multi
            // Shift the last flag through the adder-latency delay line
            always_ff @(posedge clk) begin
                if (reset)
                    r_last_pipe <= '0;
                else
                    r_last_pipe <= {r_last_pipe[c_l_add-2:0], w_last};
            end
        end else begin : g_last_pipe_single
            // Single-stage delay for a one-cycle adder
            always_ff @(posedge clk) begin
                if (reset)
                    r_last_pipe <= '0;
                else
                    r_last_pipe <= w_last;
            end
        end
    endgenerate

    // ---------------- stage B: ReLU and output register -------------------
    logic                  w_relu_zero;
    logic [DATA_WIDTH-1:0] r_pxl_out;
    logic                  r_valid_out, r_frame_done;

    // Any set sign bit (negatives, -0, negative NaN) clamps to +0
    assign w_relu_zero = (RELU_EN != 0) && w_sum[c_sign_bit];

    // Output register holds its value between valid samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pxl_out    <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= w_add_valid;
            r_frame_done <= w_add_valid & r_last_pipe[c_l_add-1];
            if (w_add_valid)
                r_pxl_out <= w_relu_zero ? c_fp32_zero : w_sum;
        end
    end

    assign pxl_out     = r_pxl_out;
    assign valid_out   = r_valid_out;
    assign bias_loaded = r_bias_loaded;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire
